// File: rtl/grid_cursor_gen_if.sv
// grid_cursor_gen_if
// Groups the pixel-position, frame-timing, button and cursor-output signals
// of grid_cursor_gen into a single bundle.
//   master : the VGA/controller side (drives coordinates, ticks and buttons)
//   slave  : the cursor generator itself
// Signals:
//   cuentaX/cuentaY  current pixel coordinate (CW bits)
//   frame_tick       one-cycle pulse at start of vertical blank
//   mv_*             one-cycle move requests
//   sel_lock         high: move requests ignored
//   blink_en         high: cursor blinks
//   cur_row/cur_col  committed cursor position
//   cur_idx          cur_row*COLS+cur_col
//   inrect/inborder  registered pixel flags for the selected cell
interface grid_cursor_gen_if #(
  parameter int CW  = 10,
  parameter int RW  = 2,
  parameter int CLW = 2,
  parameter int IW  = 4
);
  logic [CW-1:0]  cuentaX;
  logic [CW-1:0]  cuentaY;
  logic           frame_tick;
  logic           mv_up;
  logic           mv_down;
  logic           mv_left;
  logic           mv_right;
  logic           sel_lock;
  logic           blink_en;
  logic [RW-1:0]  cur_row;
  logic [CLW-1:0] cur_col;
  logic [IW-1:0]  cur_idx;
  logic           inrect;
  logic           inborder;

  modport master (
    output cuentaX, cuentaY, frame_tick, mv_up, mv_down, mv_left, mv_right,
           sel_lock, blink_en,
    input  cur_row, cur_col, cur_idx, inrect, inborder
  );

  modport slave (
    input  cuentaX, cuentaY, frame_tick, mv_up, mv_down, mv_left, mv_right,
           sel_lock, blink_en,
    output cur_row, cur_col, cur_idx, inrect, inborder
  );
endinterface

// File: rtl/grid_cursor_gen.sv
// grid_cursor_gen
// Selection-cursor generator for a ROWS x COLS board drawn on a VGA screen.
// Move pulses are collected into one pending register per axis and applied
// only on frame_tick, so a frame never shows a half-moved cursor. For the
// current pixel it produces registered "inside selected cell" and "inside
// the cell's outline band" flags, optionally blanked by a frame-counted blink.
// Ports:
//   clk        pixel/system clock, the only clock
//   boton_rst  synchronous active-low reset
//   bus        grid_cursor_gen_if.slave: pixel coordinates, frame_tick,
//              move buttons, sel_lock, blink_en in; cur_row, cur_col,
//              cur_idx, inrect, inborder out
module grid_cursor_gen #(
  parameter int COLS         = 3,
  parameter int ROWS         = 3,
  parameter int CW           = 10,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int CELL_W       = 213,
  parameter int CELL_H       = 160,
  parameter int BORDER       = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int IW           = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              boton_rst,
  grid_cursor_gen_if.slave  bus
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int WW  = CW + 2;

  // The grid must fit inside the coordinate space.
  generate
    if (longint'(ORIGIN_X) + longint'(COLS) * longint'(CELL_W) > (longint'(1) << CW)) begin : g_bad_x
      $error("grid_cursor_gen: grid exceeds horizontal coordinate range");
    end
    if (longint'(ORIGIN_Y) + longint'(ROWS) * longint'(CELL_H) > (longint'(1) << CW)) begin : g_bad_y
      $error("grid_cursor_gen: grid exceeds vertical coordinate range");
    end
  endgenerate

  typedef enum logic [1:0] {
    MV_NONE = 2'b00,
    MV_INC  = 2'b01,
    MV_DEC  = 2'b10
  } mv_e;

  mv_e            pend_v_q, pend_v_d;
  mv_e            pend_h_q, pend_h_d;
  logic [RW-1:0]  cur_row_q, cur_row_d;
  logic [CLW-1:0] cur_col_q, cur_col_d;
  logic [IW-1:0]  cur_idx_q, cur_idx_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_vis_q, blink_vis_d;
  logic           rect_raw_q, rect_raw_d;
  logic           band_raw_q, band_raw_d;

  logic           v_req, h_req, moved;
  logic [WW-1:0]  x0, x1, y0, y1, px, py;

  // Opposite buttons pressed together cancel to "no move".
  function automatic mv_e req_dir(input logic dec, input logic inc);
    if (inc && !dec)      return MV_INC;
    else if (dec && !inc) return MV_DEC;
    else                  return MV_NONE;
  endfunction

  // Pending moves: a tick consumes the old value; a pulse in the same
  // cycle as the tick becomes the new pending value for the next frame.
  always_comb begin
    v_req    = (bus.mv_up | bus.mv_down) & ~bus.sel_lock;
    h_req    = (bus.mv_left | bus.mv_right) & ~bus.sel_lock;
    pend_v_d = pend_v_q;
    pend_h_d = pend_h_q;
    if (bus.frame_tick) begin
      pend_v_d = MV_NONE;
      pend_h_d = MV_NONE;
    end
    if (v_req) pend_v_d = req_dir(bus.mv_up, bus.mv_down);
    if (h_req) pend_h_d = req_dir(bus.mv_left, bus.mv_right);
  end

  // Commit with independent wrap-around per axis; the index follows the
  // new position in the same edge.
  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    if (bus.frame_tick) begin
      case (pend_v_q)
        MV_INC:  cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
        MV_DEC:  cur_row_d = (cur_row_q == '0) ? RW'(ROWS - 1) : cur_row_q - RW'(1);
        default: cur_row_d = cur_row_q;
      endcase
      case (pend_h_q)
        MV_INC:  cur_col_d = (cur_col_q == CLW'(COLS - 1)) ? '0 : cur_col_q + CLW'(1);
        MV_DEC:  cur_col_d = (cur_col_q == '0) ? CLW'(COLS - 1) : cur_col_q - CLW'(1);
        default: cur_col_d = cur_col_q;
      endcase
    end
    moved     = (cur_row_d != cur_row_q) || (cur_col_d != cur_col_q);
    cur_idx_d = IW'(cur_row_d) * IW'(COLS) + IW'(cur_col_d);
  end

  // Blink: counts ticks per half-period; a real move restarts it visible
  // so the user always sees where the cursor landed.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (!bus.blink_en) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (bus.frame_tick) begin
      if (moved) begin
        blink_cnt_d = '0;
        blink_vis_d = 1'b1;
      end else if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  // Cell geometry in CW+2 bits so the right/bottom edges never overflow.
  always_comb begin
    px = {2'b00, bus.cuentaX};
    py = {2'b00, bus.cuentaY};
    x0 = WW'(ORIGIN_X) + WW'(cur_col_q) * WW'(CELL_W);
    x1 = x0 + WW'(CELL_W);
    y0 = WW'(ORIGIN_Y) + WW'(cur_row_q) * WW'(CELL_H);
    y1 = y0 + WW'(CELL_H);
    rect_raw_d = (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    band_raw_d = rect_raw_d &&
                 ((px < x0 + WW'(BORDER)) || (px >= x1 - WW'(BORDER)) ||
                  (py < y0 + WW'(BORDER)) || (py >= y1 - WW'(BORDER)));
  end

  always_ff @(posedge clk) begin
    if (!boton_rst) begin
      pend_v_q    <= MV_NONE;
      pend_h_q    <= MV_NONE;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      cur_idx_q   <= '0;
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
      rect_raw_q  <= 1'b0;
      band_raw_q  <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_h_q    <= pend_h_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      cur_idx_q   <= cur_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
      rect_raw_q  <= rect_raw_d;
      band_raw_q  <= band_raw_d;
    end
  end

  // The pixel flags keep tracking while hidden; only the outputs blank.
  assign bus.cur_row  = cur_row_q;
  assign bus.cur_col  = cur_col_q;
  assign bus.cur_idx  = cur_idx_q;
  assign bus.inrect   = rect_raw_q & blink_vis_q;
  assign bus.inborder = band_raw_q & blink_vis_q;

endmodule

// File: tb/tb_grid_cursor_gen.sv
// tb_grid_cursor_gen
// Directed bench for grid_cursor_gen with a frame-level cursor model and
// literal expectations for the key scenarios.
module tb_grid_cursor_gen;

  localparam int COLS   = 3;
  localparam int ROWS   = 3;
  localparam int CW     = 10;
  localparam int CELL_W = 213;
  localparam int CELL_H = 160;
  localparam int BORDER = 4;
  localparam int BF     = 2;
  localparam int RW     = 2;
  localparam int CLW    = 2;
  localparam int IW     = 4;

  logic clk = 1'b1;
  logic rst_n;
  logic chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   m_row, m_col, m_pv, m_ph, m_cnt;
  bit   m_hid, m_rin, m_rbd;

  grid_cursor_gen_if #(.CW(CW), .RW(RW), .CLW(CLW), .IW(IW)) bus ();

  grid_cursor_gen #(
    .COLS(COLS), .ROWS(ROWS), .CW(CW), .ORIGIN_X(0), .ORIGIN_Y(0),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .BORDER(BORDER),
    .BLINK_FRAMES(BF), .IW(IW)
  ) dut (
    .clk(clk),
    .boton_rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One cycle of stimulus: pulses are held across exactly one rising edge.
  task automatic applyStimulus(input logic ft, input logic up, input logic dn,
                               input logic lf, input logic rt);
    bus.frame_tick = ft;
    bus.mv_up      = up;
    bus.mv_down    = dn;
    bus.mv_left    = lf;
    bus.mv_right   = rt;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.mv_up      = 1'b0;
    bus.mv_down    = 1'b0;
    bus.mv_left    = 1'b0;
    bus.mv_right   = 1'b0;
  endtask

  // Cursor model: positions as integers, wrap by modulo, geometry straight
  // from cell extents. Advanced on the falling edge with the inputs that
  // the next rising edge will see; compared first against the DUT state.
  initial begin
    int x0, y0, nv, nh, nr, nc;
    bit in_cell, moved;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checkOutput("cmp_row",      32'(bus.cur_row),  32'(m_row));
        checkOutput("cmp_col",      32'(bus.cur_col),  32'(m_col));
        checkOutput("cmp_idx",      32'(bus.cur_idx),  32'(m_row * COLS + m_col));
        checkOutput("cmp_inrect",   32'(bus.inrect),   32'(m_rin && !m_hid));
        checkOutput("cmp_inborder", 32'(bus.inborder), 32'(m_rbd && !m_hid));
      end
      if (!rst_n) begin
        m_row = 0; m_col = 0; m_pv = 0; m_ph = 0; m_cnt = 0;
        m_hid = 0; m_rin = 0; m_rbd = 0;
      end else begin
        x0      = m_col * CELL_W;
        y0      = m_row * CELL_H;
        in_cell = (int'(bus.cuentaX) >= x0) && (int'(bus.cuentaX) < x0 + CELL_W) &&
                  (int'(bus.cuentaY) >= y0) && (int'(bus.cuentaY) < y0 + CELL_H);
        m_rin   = in_cell;
        m_rbd   = in_cell && ((int'(bus.cuentaX) < x0 + BORDER) ||
                              (int'(bus.cuentaX) >= x0 + CELL_W - BORDER) ||
                              (int'(bus.cuentaY) < y0 + BORDER) ||
                              (int'(bus.cuentaY) >= y0 + CELL_H - BORDER));
        nv = (bus.mv_down ? 1 : 0) - (bus.mv_up ? 1 : 0);
        nh = (bus.mv_right ? 1 : 0) - (bus.mv_left ? 1 : 0);
        if (bus.frame_tick) begin
          nr    = (m_row + m_pv + ROWS) % ROWS;
          nc    = (m_col + m_ph + COLS) % COLS;
          moved = (nr != m_row) || (nc != m_col);
          m_row = nr;
          m_col = nc;
          m_pv  = 0;
          m_ph  = 0;
          if (!bus.blink_en || moved) begin
            m_cnt = 0; m_hid = 0;
          end else if (m_cnt == BF - 1) begin
            m_cnt = 0; m_hid = !m_hid;
          end else begin
            m_cnt++;
          end
        end else if (!bus.blink_en) begin
          m_cnt = 0; m_hid = 0;
        end
        if (!bus.sel_lock && (bus.mv_up || bus.mv_down))    m_pv = nv;
        if (!bus.sel_lock && (bus.mv_left || bus.mv_right)) m_ph = nh;
      end
    end
  end

  int tpx[7] = '{213, 220, 426, 212, 425, 217, 216};
  int tpy[7] = '{160, 170, 170, 160, 319, 164, 200};
  int trc[7] = '{1, 1, 0, 0, 1, 1, 1};
  int tbd[7] = '{1, 0, 0, 0, 1, 0, 1};
  int tbl[6] = '{1, 0, 0, 1, 1, 0};

  initial begin
    rst_n = 1'b0;
    bus.cuentaX = '0; bus.cuentaY = '0;
    bus.frame_tick = 1'b0; bus.mv_up = 1'b0; bus.mv_down = 1'b0;
    bus.mv_left = 1'b0; bus.mv_right = 1'b0;
    bus.sel_lock = 1'b0; bus.blink_en = 1'b0;

    applyStimulus(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_row",      32'(bus.cur_row),  0);
    checkOutput("rst_col",      32'(bus.cur_col),  0);
    checkOutput("rst_idx",      32'(bus.cur_idx),  0);
    checkOutput("rst_inrect",   32'(bus.inrect),   0);
    checkOutput("rst_inborder", 32'(bus.inborder), 0);
    rst_n = 1'b1;

    // Move waits for the frame tick
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("no_tick_col", 32'(bus.cur_col), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("tick_col", 32'(bus.cur_col), 1);
    checkOutput("tick_idx", 32'(bus.cur_idx), 1);

    // Up from row 0 wraps to 2; right to col 2
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("to22_row", 32'(bus.cur_row), 2);
    checkOutput("to22_col", 32'(bus.cur_col), 2);
    checkOutput("to22_idx", 32'(bus.cur_idx), 8);

    // Both axes wrap forward together
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wrap_row", 32'(bus.cur_row), 0);
    checkOutput("wrap_col", 32'(bus.cur_col), 0);
    checkOutput("wrap_idx", 32'(bus.cur_idx), 0);

    // Later left+right overwrites an earlier right with "no move"
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lr_cancel_col", 32'(bus.cur_col), 0);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("left_wrap_col", 32'(bus.cur_col), 2);

    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("to11_idx", 32'(bus.cur_idx), 4);

    // Pixel flags around cell (1,1): x 213..425, y 160..319
    for (int i = 0; i < 7; i++) begin
      bus.cuentaX = CW'(tpx[i]);
      bus.cuentaY = CW'(tpy[i]);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("pix%0d_inrect", i),   32'(bus.inrect),   32'(trc[i]));
      checkOutput($sformatf("pix%0d_inborder", i), 32'(bus.inborder), 32'(tbd[i]));
    end

    // Blink with two ticks per half-period
    bus.cuentaX = CW'(300);
    bus.cuentaY = CW'(200);
    bus.blink_en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("blink_start", 32'(bus.inrect), 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("blink_tick%0d", i + 1), 32'(bus.inrect), 32'(tbl[i]));
    end

    // Commit while hidden restarts visible; pixel now in cell (1,2)
    bus.cuentaX = CW'(500);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("commit_vis_col",    32'(bus.cur_col), 2);
    checkOutput("commit_vis_inrect", 32'(bus.inrect),  1);
    bus.blink_en = 1'b0;

    // sel_lock ignores pulses; a pulse on the tick waits a frame
    bus.sel_lock = 1'b1;
    applyStimulus(0, 0, 1, 0, 0);
    bus.sel_lock = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lock_row", 32'(bus.cur_row), 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("same_tick_row", 32'(bus.cur_row), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("next_tick_row", 32'(bus.cur_row), 2);

    // Reset while hidden with a move pending; pixel inside cell (2,2)
    bus.cuentaY = CW'(400);
    bus.blink_en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("pre_rst_vis", 32'(bus.inrect), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("pre_rst_hidden", 32'(bus.inrect), 0);
    applyStimulus(0, 0, 1, 0, 1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_rst_row",      32'(bus.cur_row),  0);
    checkOutput("mid_rst_col",      32'(bus.cur_col),  0);
    checkOutput("mid_rst_idx",      32'(bus.cur_idx),  0);
    checkOutput("mid_rst_inrect",   32'(bus.inrect),   0);
    checkOutput("mid_rst_inborder", 32'(bus.inborder), 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("post_rst_row", 32'(bus.cur_row), 0);
    checkOutput("post_rst_col", 32'(bus.cur_col), 0);
    bus.blink_en = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_cursor_gen.md
Name:
grid_cursor_gen

Overview:
- Parametrised selection-cursor generator for the VGA board view.
- Owns the ROWS x COLS cursor position as registered state and moves it from single-cycle button pulses.
- Position changes are committed only at frame boundaries, so no frame shows a torn cursor.
- Drives registered filled-cell (inrect) and outline (inborder) pixel flags, with optional blinking.

Parameters:
- COLS, 3, grid columns (>=1)
- ROWS, 3, grid rows (>=1)
- CW, 10, pixel-coordinate width
- ORIGIN_X, 0, x of the grid's left edge
- ORIGIN_Y, 0, y of the grid's top edge
- CELL_W, 213, cell width in pixels
- CELL_H, 160, cell height in pixels
- BORDER, 4, outline thickness in pixels (1 <= BORDER <= min(CELL_W,CELL_H)/2)
- BLINK_FRAMES, 30, frame_ticks per blink half-period (>=1)
- IW, $clog2(ROWS*COLS) (min 1), width of cur_idx

Ports:
- clk  in  1  system/pixel clock; the only clock
- boton_rst  in  1  synchronous, active-low reset
- cuentaX  in  CW  current pixel x
- cuentaY  in  CW  current pixel y
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- mv_up, mv_down, mv_left, mv_right  in  1 each  one-cycle move requests
- sel_lock  in  1  high: move requests ignored
- blink_en  in  1  high: cursor blinks
- cur_row  out  $clog2(ROWS) (min 1)  committed row
- cur_col  out  $clog2(COLS) (min 1)  committed column
- cur_idx  out  IW  cur_row*COLS+cur_col, registered
- inrect  out  1  pixel lies inside the selected cell
- inborder  out  1  pixel lies inside the selected cell's outline band

Behaviour:
- Clock and reset: all state updates on posedge clk. boton_rst==0 at an edge forces:
  - cur_row=0, cur_col=0, cur_idx=0
  - pending moves cleared
  - blink counter=0, blink phase=visible
  - inrect=0, inborder=0
  - Reset overrides every other input in the same cycle. Reset mid-move discards the pending move.
- Pending moves: one pending register per axis, values -1 / 0 / +1.
  - A move pulse with sel_lock==0 overwrites that axis' pending value, so the latest request per axis wins.
  - mv_up and mv_down in the same cycle: vertical pending set to 0. Same rule for mv_left and mv_right.
  - Horizontal and vertical requests in the same cycle both register.
  - sel_lock==1: pulses ignored; existing pending values are kept.
- Commit: on a frame_tick cycle, pending values are applied to cur_row/cur_col, then cleared.
  - A pulse arriving in the same cycle as frame_tick is not committed; it becomes pending for the next tick.
- Wrap-around:
  - col COLS-1 +1 -> 0; col 0 -1 -> COLS-1 (same row).
  - row ROWS-1 +1 -> 0; row 0 -1 -> ROWS-1 (same column).
  - No carry between axes.
- cur_idx is updated in the same edge as cur_row/cur_col.
- Geometry, using the committed position:
  - x0 = ORIGIN_X + cur_col*CELL_W, x1 = x0 + CELL_W; y0 = ORIGIN_Y + cur_row*CELL_H, y1 = y0 + CELL_H.
  - All arithmetic is in CW+2 bits, unsigned, with no truncation before comparison.
  - in_cell = x0 <= cuentaX < x1 and y0 <= cuentaY < y1 (left/top inclusive, right/bottom exclusive).
  - band = in_cell and (cuentaX < x0+BORDER or cuentaX >= x1-BORDER or cuentaY < y0+BORDER or cuentaY >= y1-BORDER).
- Outputs: inrect and inborder are registered with exactly 1 clk of latency from cuentaX/cuentaY, then gated by blink phase.
- Blink:
  - blink_en==0: counter held at 0, phase=visible.
  - blink_en==1: counter increments on each frame_tick. When it reaches BLINK_FRAMES-1 and a tick arrives, it resets to 0 and the phase toggles.
  - A commit that changes position forces counter=0 and phase=visible.
  - Phase hidden: inrect=0 and inborder=0; the registered path still updates.
- Elaboration must fail if ORIGIN_X+COLS*CELL_W > 2^CW or ORIGIN_Y+ROWS*CELL_H > 2^CW.

Test Plan:
- Reset, then pulse mv_right without frame_tick -> cur_col stays 0. Next frame_tick -> cur_col=1 and cur_idx=1 one edge later.
- From (row 2, col 2), mv_right and mv_down in the same cycle, then a tick -> (0,0), cur_idx=0. Separately, mv_left with mv_right, then a tick -> column unchanged.
- Defaults at cell (1,1), per cycle:
  - (213,160) -> inrect=1, inborder=1 on the next cycle
  - (220,170) -> inrect=1, inborder=0
  - (426,170) -> 0/0
  - (212,160) -> 0/0
- blink_en=1, BLINK_FRAMES=2, at a fixed pixel inside the cell -> inrect follows 1,1,0,0,1 across successive frame_ticks. Committing a move while hidden -> visible on the next cycle.
- sel_lock=1 with mv_down pulsed, then a tick -> row unchanged. Pulse mv_down together with frame_tick -> row changes only at the following tick.
- Assert boton_rst low for one cycle while a move is pending and blink is hidden -> all outputs 0 and position (0,0). A subsequent tick does not move the cursor.
